input_debouncer: RTL and testbench

//  Conditions a raw, asynchronous, bouncy level input (button/switch) before it reaches the design's registered inputs.
//  - Stage 1: two-flop synchronizer.
//  - Stage 2: FSM/counter that accepts a new level only after STABLE_CYCLES consecutive agreeing samples.
//  - Outputs: a clean level plus single-cycle rise/fall pulses, all registered.

---
 rtl/debounce_pkg.sv | 18 +
 rtl/sync_2ff.sv | 32 +++
 rtl/input_debouncer.sv | 167 ++++++++++++++++
 tb/tb_input_debouncer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the input debouncer.
//   db_state_t : debouncer FSM states
//   GLITCH_W   : width of the optional aborted-pend counter
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  localparam int GLITCH_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level. Both flops clear to 0
// on a synchronous, active-high reset.
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous active-high reset
//   d_i   in  1  asynchronous input
//   q_o   out 1  synchronized level (two clocks of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d_i;
      r_s2 <= r_s1;
    end
  end

  assign q_o = r_s2;

endmodule

// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
// Conditions a raw bouncy level (button/switch): two-flop synchronizer, then an
// FSM that accepts a new level only after STABLE_CYCLES consecutive agreeing
// synchronized samples. All outputs are registered.
//
// Optional build macro: DEBOUNCE_GLITCH_CNT_EN adds glitch_cnt_o, a saturating
// count of pending changes that were aborted by a bounce.
//
// Ports
//   clk          in  1  rising-edge clock
//   reset        in  1  synchronous active-high reset
//   d_i          in  1  raw asynchronous level
//   level_o      out 1  debounced level
//   rise_o       out 1  one-cycle pulse in the first cycle level_o reads 1
//   fall_o       out 1  one-cycle pulse in the first cycle level_o reads 0
//   glitch_cnt_o out 8  aborted-pend count (DEBOUNCE_GLITCH_CNT_EN only)
//
// state     | meaning
// STABLE_LO | accepted level 0, waiting for a 1 sample
// PEND_HI   | counting consecutive 1 samples toward accepting 1
// STABLE_HI | accepted level 1, waiting for a 0 sample
// PEND_LO   | counting consecutive 0 samples toward accepting 0
// -----------------------------------------------------------------------------
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [GLITCH_W-1:0] glitch_cnt_o
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
    $error("input_debouncer: STABLE_CYCLES must be >= 2");
  end

  logic             w_s;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             w_level_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             w_abort;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (d_i),
    .q_o   (w_s)
  );

  // r_cnt holds the number of agreeing samples already taken in a pending
  // state, so the sample that matches at CNT_LAST is the STABLE_CYCLES-th one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      STABLE_LO: begin
        if (w_s) begin
          w_state_nxt = PEND_HI;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PEND_HI: begin
        if (!w_s) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!w_s) begin
          w_state_nxt = PEND_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      PEND_LO: begin
        if (w_s) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_abort     = 1'b1;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
        w_level_nxt = 1'b0;
      end
    endcase
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] r_glitch_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      r_glitch_cnt <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      // saturate rather than wrap so a noisy line never reads as quiet
      if (w_abort && (r_glitch_cnt != '1)) begin
        r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
      end
`endif
    end
  end

  assign level_o = r_level;
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  assign glitch_cnt_o = r_glitch_cnt;
`else
  logic w_abort_unused;
  assign w_abort_unused = w_abort;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
// Self-checking bench for input_debouncer with STABLE_CYCLES = 4. The reference
// model keeps the history of synchronized samples and flips its level when the
// most recent STABLE_CYCLES samples all disagree with the current level.
// -----------------------------------------------------------------------------
module tb_input_debouncer;
  import debounce_pkg::*;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic d_i   = 1'b0;
  logic level_o, rise_o, fall_o;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  input_debouncer #(.STABLE_CYCLES(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_i     (d_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    .glitch_cnt_o (glitch_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // reference model
  bit m_s1, m_s, m_level, m_rise, m_fall;
  int m_gl;
  bit hist[$];

  always @(posedge clk) begin
    bit flip;
    if (reset) begin
      m_s1 = 0; m_s = 0; m_level = 0; m_rise = 0; m_fall = 0; m_gl = 0;
      hist.delete();
    end else begin
      m_rise = 0;
      m_fall = 0;
      hist.push_back(m_s);
      flip = (hist.size() >= N);
      if (flip) begin
        for (int i = 0; i < N; i++)
          if (hist[hist.size()-1-i] == m_level) flip = 0;
      end
      if (flip) begin
        m_level = ~m_level;
        if (m_level) m_rise = 1; else m_fall = 1;
        hist.delete();
      end else if (hist.size() >= 2 && hist[hist.size()-1] == m_level &&
                   hist[hist.size()-2] != m_level) begin
        if (m_gl < 255) m_gl++;
      end
      if (hist.size() > N + 1) void'(hist.pop_front());
      m_s  = m_s1;
      m_s1 = d_i;
    end
  end

  task automatic idle(input logic val, input int cycles);
    d_i = val;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; d_i = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold: got lvl/rise/fall=%b want 000", {level_o, rise_o, fall_o});
      end
    end
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if (level_o !== 1'b0 || rise_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got lvl=%b rise=%b want 0 0", level_o, rise_o);
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt_o !== 8'd0) begin
      n_err++;
      $display("FAIL reset_glitch: got %0d want 0", glitch_cnt_o);
    end
`endif
  endtask

  task automatic test_rise();
    idle(1'b0, 14);
    d_i = 1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL rise_model[%0d]: got %b want %b", i, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
      if (i == 5 || i == 6 || i == 7) begin
        n_cmp++;
        if ({level_o, rise_o} !== ((i == 5) ? 2'b00 : (i == 6) ? 2'b11 : 2'b10)) begin
          n_err++;
          $display("FAIL rise_latency[%0d]: got lvl/rise=%b%b", i, level_o, rise_o);
        end
      end
    end
  endtask

  task automatic test_glitch_hi();
    int g0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    g0 = int'(glitch_cnt_o);
`else
    g0 = 0;
`endif
    for (int i = 0; i < 14; i++) begin
      d_i = (i < 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      n_cmp++;
      if (level_o !== 1'b1 || fall_o !== 1'b0 || rise_o !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_hold[%0d]: got lvl=%b rise=%b fall=%b want 1 0 0", i, level_o, rise_o, fall_o);
      end
    end
`ifdef DEBOUNCE_GLITCH_CNT_EN
    n_cmp++;
    if (int'(glitch_cnt_o) !== g0 + 1 || int'(glitch_cnt_o) !== m_gl) begin
      n_err++;
      $display("FAIL glitch_count: got %0d want %0d", glitch_cnt_o, g0 + 1);
    end
`else
    if (g0 != 0) $display("note: unexpected glitch baseline %0d", g0);
`endif
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 20; i++) begin
      d_i = i[0];
      @(negedge clk);
      n_cmp++;
      if (level_o !== 1'b1 || rise_o !== 1'b0 || fall_o !== 1'b0) begin
        n_err++;
        $display("FAIL toggle[%0d]: got lvl=%b rise=%b fall=%b want 1 0 0", i, level_o, rise_o, fall_o);
      end
    end
    d_i = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      n_cmp++;
      if ({level_o, fall_o} !== ((j < 6) ? 2'b10 : (j == 6) ? 2'b01 : 2'b00)) begin
        n_err++;
        $display("FAIL toggle_fall[%0d]: got lvl/fall=%b%b", j, level_o, fall_o);
      end
    end
  endtask

  task automatic test_reset_pending();
    d_i = 1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (dut.r_state !== PEND_HI || int'(dut.r_cnt) !== 2) begin
      n_err++;
      $display("FAIL pend_setup: got state=%0d cnt=%0d want 1 2", dut.r_state, dut.r_cnt);
    end
    reset = 1; d_i = 0;
    @(negedge clk);
    n_cmp++;
    if (dut.r_state !== STABLE_LO || level_o !== 1'b0 || rise_o !== 1'b0) begin
      n_err++;
      $display("FAIL pend_reset: got state=%0d lvl=%b rise=%b want 0 0 0", dut.r_state, level_o, rise_o);
    end
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (level_o !== 1'b0 || rise_o !== 1'b0) begin
        n_err++;
        $display("FAIL pend_release[%0d]: got lvl=%b rise=%b want 0 0", i, level_o, rise_o);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    for (int c = 0; c < 800; ) begin
      d_i = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 7));
      for (int h = 0; h < hold; h++, c++) begin
        reset = ($urandom_range(0, 99) < 2);
        @(negedge clk);
        n_cmp++;
        if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
          n_err++;
          $display("FAIL random[%0d]: got %b want %b", c, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        n_cmp++;
        if (int'(glitch_cnt_o) !== m_gl) begin
          n_err++;
          $display("FAIL random_glitch[%0d]: got %0d want %0d", c, glitch_cnt_o, m_gl);
        end
`endif
      end
    end
    reset = 0;
  endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
  task automatic test_glitch_sat();
    reset = 1; d_i = 0;
    @(negedge clk);
    reset = 0;
    idle(1'b0, 4);
    for (int i = 0; i < 300; i++) begin
      idle(1'b1, 2);
      idle(1'b0, 3);
    end
    idle(1'b0, 6);
    n_cmp++;
    if (glitch_cnt_o !== 8'd255 || m_gl != 255) begin
      n_err++;
      $display("FAIL glitch_sat: got %0d want 255 (model %0d)", glitch_cnt_o, m_gl);
    end
    n_cmp++;
    if (level_o !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_sat_level: got %b want 0", level_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rise();
    test_glitch_hi();
    test_toggle();
    test_reset_pending();
    test_random();
`ifdef DEBOUNCE_GLITCH_CNT_EN
    test_glitch_sat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
